serial_adder_ctrl: RTL and testbench
====================================

Name: serial_adder_ctrl

Overview:
- Bit-serial add controller: sequences a single 1-bit full_adder cell over WIDTH-bit operands, LSB first, one bit per clock.
- Start/done handshake toward the requester. Carry is registered between bits.
- Lets small designs share one full adder instead of a WIDTH-bit ripple adder.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a_in  input  WIDTH  operand A; captured when start is accepted
- b_in  input  WIDTH  operand B; captured when start is accepted
- cin_in  input  1  carry-in; captured when start is accepted
- busy  output  1  high whenever state != IDLE
- done  output  1  one-cycle pulse; result valid
- sum_out  output  WIDTH  result; held until the next completion
- cout_out  output  1  final carry; held with sum_out

Behaviour:
- Reset: on posedge clk with rst=1, all outputs go to 0 the same edge.
  - state=IDLE, bit_cnt=0, carry reg=0, shift regs=0.
  - rst has priority over every other input, including mid-RUN. The partial result is discarded and sum_out/cout_out go to 0.
- FSM states: IDLE, RUN, DONE.
  - IDLE -> RUN when start=1.
    - Load a_sh=a_in, b_sh=b_in, carry=cin_in, bit_cnt=0.
    - Clear the result shift reg.
  - RUN: each cycle, feed a_sh[0], b_sh[0], carry into one full_adder instance.
    - Shift the sum bit into r_sh at the MSB (right shift).
    - Shift a_sh and b_sh right by 1.
    - carry <= carry-out.
    - bit_cnt++.
  - RUN -> DONE on the cycle where bit_cnt == WIDTH-1 (the WIDTH-th RUN cycle).
    - That same edge: sum_out <= final r_sh including the last bit, cout_out <= final carry.
  - DONE: done=1 for exactly one cycle, then unconditionally -> IDLE.
- Latency: start sampled at edge E0. Cycles E1..E_WIDTH are RUN. done=1 during the cycle after edge E_WIDTH, i.e. WIDTH+1 clocks after the start edge.
  - Back-to-back: start held high in the first IDLE cycle after DONE is accepted.
  - Throughput is one add per WIDTH+2 cycles.
- start while busy (RUN or DONE): ignored. No queuing, no error flag.
- Operand inputs are don't-care except on the accepting edge. Changes during RUN have no effect.
- sum_out/cout_out change only at the RUN->DONE edge or on reset. They are stable during the next operation.
- Arithmetic: sum_out = (a_in + b_in + cin_in) mod 2^WIDTH; cout_out = bit WIDTH of the full sum.
- bit_cnt width = clog2(WIDTH)+1. No wrap-around reachable.

Optional Feature:
- Macro: SERIAL_ADDER_SUB_EN.
- Defined: extra input port op_sub (1 bit), captured with the operands.
  - op_sub=1: load b_sh=~b_in and force carry=1 (cin_in ignored). Result is a_in - b_in mod 2^WIDTH.
  - cout_out=1 means no borrow (a_in >= b_in unsigned).
  - op_sub=0: identical to the base behaviour.
- Undefined: port op_sub does not exist. Add-only behaviour. Gate count identical to the base design.

Test Plan (WIDTH=8):
- Reset, then start with a=8'h0F, b=8'h01, cin=0 -> busy high for 9 cycles, done pulses once 9 clocks after the start edge; sum_out=8'h10, cout_out=0.
- a=8'hFF, b=8'h01, cin=0 -> sum_out=8'h00, cout_out=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum_out=8'hFF, cout_out=1.
- During RUN, pulse start and change a_in/b_in -> no restart; result matches the originally captured operands; done pulses exactly once.
- Assert rst at the 4th RUN cycle -> next edge: busy=0, done=0, sum_out=0, cout_out=0. A fresh start of 8'h03+8'h04 then gives 8'h07.
- Hold start high continuously across two ops (8'h01+8'h01, then 8'h80+8'h80) -> results 8'h02/cout 0, then 8'h00/cout 1. done pulses 10 cycles apart; sum_out holds 8'h02 until the second DONE.
- SERIAL_ADDER_SUB_EN defined: op_sub=1, a=8'h05, b=8'h07 -> sum_out=8'hFE, cout_out=0. Then a=8'h07, b=8'h05 -> 8'h02, cout_out=1.

Source files
------------

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one shared full-adder cell walks WIDTH-bit operands LSB first.
// Optional subtract mode (op_sub port) is enabled by defining SERIAL_ADDER_SUB_EN.

module full_adder (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);
   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_adder_ctrl #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
`ifdef SERIAL_ADDER_SUB_EN
   input  logic             op_sub,
`endif
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             cin_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum_out,
   output logic             cout_out
);
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sh, b_sh, r_sh;
   logic [WIDTH-1:0] b_ld;
   logic             c_ld;
   logic             carry;
   logic [CW-1:0]    bit_cnt;
   logic             fa_s, fa_co;
   logic             last_bit;

   assign last_bit = (bit_cnt == CW'(WIDTH - 1));

   full_adder u_fa (
      .a  (a_sh[0]),
      .b  (b_sh[0]),
      .ci (carry),
      .s  (fa_s),
      .co (fa_co)
   );

   // Subtraction is a + ~b + 1, so op_sub inverts b and forces the carry-in
   always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
      b_ld = op_sub ? ~b_in : b_in;
      c_ld = op_sub | cin_in;
`else
      b_ld = b_in;
      c_ld = cin_in;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         RUN:     if (last_bit) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
      done = (state == DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh     <= '0;
         b_sh     <= '0;
         r_sh     <= '0;
         carry    <= 1'b0;
         bit_cnt  <= '0;
         sum_out  <= '0;
         cout_out <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start) begin
               a_sh    <= a_in;
               b_sh    <= b_ld;
               carry   <= c_ld;
               bit_cnt <= '0;
               r_sh    <= '0;
            end
            RUN: begin
               a_sh    <= a_sh >> 1;
               b_sh    <= b_sh >> 1;
               carry   <= fa_co;
               bit_cnt <= bit_cnt + CW'(1);
               r_sh    <= {fa_s, r_sh[WIDTH-1:1]};
               // Last bit goes straight to the output, not via r_sh
               if (last_bit) begin
                  sum_out  <= {fa_s, r_sh[WIDTH-1:1]};
                  cout_out <= fa_co;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Scoreboard bench for serial_adder_ctrl (WIDTH=8); subtract vectors run when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder_ctrl;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst, start, cin_in;
   logic [W-1:0] a_in, b_in;
   logic         busy, done, cout_out;
   logic [W-1:0] sum_out;
`ifdef SERIAL_ADDER_SUB_EN
   logic         op_sub;
`endif

   int checks = 0;
   int errors = 0;
   int done_seen = 0;
   int pushed = 0;
   logic [W:0] exp_q[$];
   logic prev_done = 1'b0;

   always #5 clk = ~clk;

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
`ifdef SERIAL_ADDER_SUB_EN
      .op_sub   (op_sub),
`endif
      .a_in     (a_in),
      .b_in     (b_in),
      .cin_in   (cin_in),
      .busy     (busy),
      .done     (done),
      .sum_out  (sum_out),
      .cout_out (cout_out)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: pops the scoreboard on every done pulse
   always @(negedge clk) begin
      if (done) begin
         done_seen++;
         checks++;
         if (prev_done) begin
            errors++;
            $display("FAIL done_width: done high two cycles in a row");
         end else if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: got %h/%b with empty scoreboard", sum_out, cout_out);
         end else begin
            logic [W:0] e;
            e = exp_q.pop_front();
            if ({cout_out, sum_out} !== e) begin
               errors++;
               $display("FAIL result: got cout=%b sum=%h expected cout=%b sum=%h",
                        cout_out, sum_out, e[W], e[W-1:0]);
            end
         end
      end
      prev_done <= done;
   end

   // Issue one add; returns after the negedge following the start edge
   task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
      @(negedge clk);
      start = 1'b1; a_in = a; b_in = b; cin_in = c;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int exp_lat);
      int cnt = 1;
      int bcnt = busy ? 1 : 0;
      while (!done && cnt < 40) begin
         @(negedge clk);
         cnt++;
         if (busy) bcnt++;
      end
      chk({name, "_latency"}, cnt, exp_lat);
      chk({name, "_busy_cycles"}, bcnt, exp_lat);
      @(negedge clk);
   endtask

   task automatic add_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic c, input logic [W:0] exp);
      exp_q.push_back(exp); pushed++;
      launch(a, b, c);
      wait_done(name, 9);
   endtask

`ifdef SERIAL_ADDER_SUB_EN
   task automatic sub_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W:0] exp);
      exp_q.push_back(exp); pushed++;
      op_sub = 1'b1;
      launch(a, b, 1'b0);
      op_sub = 1'b0;
      wait_done(name, 9);
   endtask
`endif

   initial begin
      rst = 1'b1; start = 1'b0; a_in = '0; b_in = '0; cin_in = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      op_sub = 1'b0;
`endif
      repeat (3) @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_sum", sum_out, 0);
      chk("rst_cout", cout_out, 0);
      rst = 1'b0;

      add_op("add_0F_01", 8'h0F, 8'h01, 1'b0, {1'b0, 8'h10});
      chk("done_low_after", done, 0);
      add_op("add_FF_01", 8'hFF, 8'h01, 1'b0, {1'b1, 8'h00});
      add_op("add_FF_FF_c", 8'hFF, 8'hFF, 1'b1, {1'b1, 8'hFF});

      // Start pulse and operand change during RUN must be ignored
      exp_q.push_back({1'b0, 8'h46}); pushed++;
      launch(8'h12, 8'h34, 1'b0);
      @(negedge clk);
      start = 1'b1; a_in = 8'hFF; b_in = 8'hFF; cin_in = 1'b1;
      @(negedge clk);
      start = 1'b0;
      begin
         int cnt = 3;
         while (!done && cnt < 40) begin @(negedge clk); cnt++; end
         chk("ignore_start_latency", cnt, 9);
      end
      repeat (12) @(negedge clk);
      chk("ignore_start_idle", busy, 0);

      // Reset in the 4th RUN cycle discards the operation
      launch(8'h55, 8'h22, 1'b0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("midrst_busy", busy, 0);
      chk("midrst_done", done, 0);
      chk("midrst_sum", sum_out, 0);
      chk("midrst_cout", cout_out, 0);
      add_op("add_03_04", 8'h03, 8'h04, 1'b0, {1'b0, 8'h07});

      // Back-to-back with start held high
      exp_q.push_back({1'b0, 8'h02}); exp_q.push_back({1'b1, 8'h00}); pushed += 2;
      @(negedge clk);
      start = 1'b1; a_in = 8'h01; b_in = 8'h01; cin_in = 1'b0;
      @(negedge clk);
      a_in = 8'h80; b_in = 8'h80;
      begin
         int first = -1, second = -1;
         for (int n = 1; n < 40 && second < 0; n++) begin
            if (n == 11) start = 1'b0;
            if (n == 15) chk("b2b_hold_sum", sum_out, 8'h02);
            if (done) begin
               if (first < 0) first = n;
               else second = n;
            end
            if (second < 0) @(negedge clk);
         end
         chk("b2b_first_done", first, 9);
         chk("b2b_spacing", second - first, 10);
      end
      start = 1'b0;
      @(negedge clk);

`ifdef SERIAL_ADDER_SUB_EN
      sub_op("sub_05_07", 8'h05, 8'h07, {1'b0, 8'hFE});
      sub_op("sub_07_05", 8'h07, 8'h05, {1'b1, 8'h02});
`endif

      repeat (4) @(negedge clk);
      chk("done_count", done_seen, pushed);
      chk("scoreboard_empty", exp_q.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end
endmodule
